jk_bank_scheduler: RTL and testbench

//   Owns a bank of WIDTH JK flip-flop cells, each cell built from a D flip-flop.
//   Two requesters send J/K commands (hold/reset/set/toggle) to an addressed cell.
//   The block arbitrates them round-robin, applies one command per 3 cycles and

---
 rtl/jk_bank_scheduler.sv | 124 ++++++++++++
 tb/tb_jk_bank_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler in front of a bank of JK cells (D flip-flops with JK next-state logic).
// Accepts one J/K command per three cycles and reports a registered completion.
module jk_bank_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_op,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done_valid,
  output logic              done_id,
  output logic              done_q,
  output logic              done_err
);

  typedef enum logic [1:0] {StIdle, StApply, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        op_q;
  logic              id_q;
  logic              last_grant_q;
  logic              grant0, grant1;
  logic              accept, accept_id;
  logic              addr_err;
  logic [WIDTH-1:0]  q_d;
  logic              cell_new;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
    req0_ready = (state_q == StIdle) && grant0;
    req1_ready = (state_q == StIdle) && grant1;
    accept     = req0_ready || req1_ready;
    accept_id  = req1_ready;
  end

  assign addr_err = (32'(addr_q) >= WIDTH);
  assign busy     = (state_q != StIdle);

  // Only the addressed cell sees a non-zero J/K; all others hold.
  always_comb begin
    q_d      = q;
    cell_new = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      logic j, k;
      j = 1'b0;
      k = 1'b0;
      if (state_q == StApply && 32'(addr_q) == i) begin
        j = op_q[1];
        k = op_q[0];
      end
      q_d[i] = (j & ~q[i]) | (~k & q[i]);
      if (state_q == StApply && 32'(addr_q) == i) begin
        cell_new = q_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StApply;
      StApply: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= accept_id ? req1_addr : req0_addr;
        op_q         <= accept_id ? req1_op : req0_op;
        id_q         <= accept_id;
        last_grant_q <= accept_id;
      end
    end
  end

  // Completion fields are loaded at the end of APPLY so they are visible during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      done_valid <= 1'b0;
      done_id    <= 1'b0;
      done_q     <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      q          <= q_d;
      done_valid <= (state_q == StApply);
      done_q     <= (state_q == StApply) && !addr_err && cell_new;
      done_err   <= (state_q == StApply) && addr_err;
      if (state_q == StApply) begin
        done_id <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: directed spec scenarios plus random traffic,
// checked every cycle against a command-level model of the bank.
module tb_jk_bank_scheduler;
  localparam int W  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [W-1:0]  q;
  logic          busy, done_valid, done_id, done_q, done_err;

  always #5 clk = ~clk;

  jk_bank_scheduler #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_op(req1_op),
    .q(q), .busy(busy), .done_valid(done_valid), .done_id(done_id), .done_q(done_q),
    .done_err(done_err)
  );

  int tests = 0;
  int fails = 0;

  // Model: bank contents, cycles since the in-flight command was accepted, and its result.
  logic [W-1:0]  m_q;
  int            phase;
  logic          m_last, m_did;
  logic [AW-1:0] p_addr;
  logic [1:0]    p_op;
  logic          p_id, res_q, res_err;
  int            cyc, acc;
  int            acc_ids[$];
  int            acc_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; phase = 0; m_last = 1'b1; m_did = 1'b0; acc = -1;
  endtask

  // One clock: check every output at the negedge, then advance the model over the posedge.
  task automatic cycle();
    int            g;
    logic [AW-1:0] ga;
    logic [1:0]    gop;
    @(negedge clk);
    g = -1;
    if (phase == 0) begin
      if (req0_valid && req1_valid) g = m_last ? 0 : 1;
      else if (req0_valid) g = 0;
      else if (req1_valid) g = 1;
    end
    ga  = (g == 1) ? req1_addr : req0_addr;
    gop = (g == 1) ? req1_op : req0_op;
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("ready_overlap", 32'(req0_ready & req1_ready), 32'(0));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("q", 32'(q), 32'(m_q));
    chk("done_valid", 32'(done_valid), 32'(phase == 2));
    chk("done_id", 32'(done_id), 32'(m_did));
    chk("done_q", 32'(done_q), 32'((phase == 2) && res_q));
    chk("done_err", 32'(done_err), 32'((phase == 2) && res_err));
    @(posedge clk);
    acc = -1;
    if (phase == 0) begin
      if (g >= 0) begin
        p_addr = ga; p_op = gop; p_id = (g == 1);
        res_err = (int'(ga) >= W);
        if (res_err) res_q = 1'b0;
        else case (gop)
          2'b00: res_q = m_q[ga];
          2'b01: res_q = 1'b0;
          2'b10: res_q = 1'b1;
          default: res_q = ~m_q[ga];
        endcase
        m_last = p_id; acc = g; phase = 1;
        acc_ids.push_back(g);
        acc_cyc.push_back(cyc);
      end
    end else if (phase == 1) begin
      if (!res_err) m_q[p_addr] = res_q;
      m_did = p_id;
      phase = 2;
    end else begin
      phase = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input bit id, input logic [AW-1:0] a, input logic [1:0] op);
    int n = 0;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_addr = a; req0_op = op; end
    else begin req1_valid = 1'b1; req1_addr = a; req1_op = op; end
    do begin cycle(); n++; end while (acc != int'(id) && n < 20);
    chk("send_accepted", 32'(acc == int'(id)), 32'(1));
    if (id == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk("rst_q", 32'(q), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done_valid), 32'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    model_reset();
    // Reset state; ready only with valid.
    do_reset();
    chk("rst_ready_novalid", 32'(req0_ready), 32'(0));
    idle(2);
    send(1'b0, 3'd0, 2'b00);
    idle(3);

    // req0 set addr 3.
    do_reset();
    send(1'b0, 3'd3, 2'b10);
    idle(1);
    chk("t2_q", 32'(q), 32'(8));
    chk("t2_done", 32'({done_valid, done_id, done_q}), 32'(3'b101));
    idle(1);

    // req1 toggle, toggle, hold on addr 3.
    acc_cyc.delete();
    send(1'b1, 3'd3, 2'b11);
    send(1'b1, 3'd3, 2'b11);
    send(1'b1, 3'd3, 2'b00);
    idle(3);
    chk("t3_q", 32'(q), 32'(8));
    chk("t3_count", 32'(acc_cyc.size()), 32'(3));
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t3_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(3));

    // Both requesters valid constantly.
    do_reset();
    acc_ids.delete();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_op = 2'b10;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_op = 2'b10;
    idle(13);
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(3);
    chk("t4_count", 32'(acc_ids.size() >= 4), 32'(1));
    if (acc_ids.size() >= 4) begin
      chk("t4_grant0", 32'(acc_ids[0]), 32'(0));
      chk("t4_grant1", 32'(acc_ids[1]), 32'(1));
      chk("t4_grant2", 32'(acc_ids[2]), 32'(0));
      chk("t4_grant3", 32'(acc_ids[3]), 32'(1));
    end
    chk("t4_q", 32'(q), 32'(6));

    // Out-of-range address, then a legal command.
    do_reset();
    send(1'b0, 3'd7, 2'b10);
    idle(1);
    chk("t5_q", 32'(q), 32'(0));
    chk("t5_err", 32'({done_valid, done_err, done_q}), 32'(3'b110));
    idle(2);
    send(1'b1, 3'd4, 2'b10);
    idle(3);
    chk("t5_legal_q", 32'(q), 32'(8'h10));

    // Reset pulse during APPLY aborts the command.
    do_reset();
    send(1'b0, 3'd5, 2'b10);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_q", 32'(q), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_done", 32'(done_valid), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd5; req0_op = 2'b10;
    cycle();
    chk("t6_accept_at_once", 32'(acc), 32'(0));
    req0_valid = 1'b0;
    idle(3);
    chk("t6_q_after", 32'(q), 32'(8'h20));

    // Random traffic, all addresses including out-of-range ones.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (acc == 0 || (!req0_valid && $urandom_range(0, 1) == 1)) begin
        req0_valid = (acc == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        req0_addr = AW'($urandom_range(0, 7)); req0_op = 2'($urandom_range(0, 3));
      end else if (req0_valid && $urandom_range(0, 9) == 0) begin
        req0_valid = 1'b0;
      end
      if (acc == 1 || (!req1_valid && $urandom_range(0, 1) == 1)) begin
        req1_valid = (acc == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        req1_addr = AW'($urandom_range(0, 7)); req1_op = 2'($urandom_range(0, 3));
      end else if (req1_valid && $urandom_range(0, 9) == 0) begin
        req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
